// File: rtl/operand_fetch_seq.sv
// operand_fetch_seq: sequences the input data latch and the ABL/ABH/PCL/PCH
// load strobes for IMM, ZP, ABS and JMP-indirect operand fetch.
module operand_fetch_seq #(
  parameter bit RDY_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       rdy,
  output logic       addr_sel,
  output logic       pc_inc,
  output logic       dl_wa,
  output logic       dl_oadb,
  output logic       dl_oaal,
  output logic       dl_oaah,
  output logic       abl_ld,
  output logic       abh_ld,
  output logic       abh_clr,
  output logic       abl_inc,
  output logic       pcl_ld,
  output logic       pch_ld,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    S_IDLE, S_F1, S_D_DB, S_D_ZP, S_F2,
    S_D_HI, S_P_SET, S_P_LO, S_P_HI, S_D_PC
  } state_t;

  localparam logic [1:0] M_IMM = 2'd0;
  localparam logic [1:0] M_ZP  = 2'd1;
  localparam logic [1:0] M_ABS = 2'd2;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_mode;
  logic       w_run;

  logic w_pc_inc, w_dl_wa, w_dl_oadb, w_dl_oaal, w_dl_oaah;
  logic w_abl_ld, w_abh_ld, w_abh_clr, w_abl_inc;
  logic w_pcl_ld, w_pch_ld, w_done;

  assign w_run = rdy | ~RDY_EN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= M_IMM;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start)
        r_mode <= mode;
    end
  end

  always_comb begin
    w_next    = r_state;
    addr_sel  = 1'b0;
    w_pc_inc  = 1'b0;
    w_dl_wa   = 1'b0;
    w_dl_oadb = 1'b0;
    w_dl_oaal = 1'b0;
    w_dl_oaah = 1'b0;
    w_abl_ld  = 1'b0;
    w_abh_ld  = 1'b0;
    w_abh_clr = 1'b0;
    w_abl_inc = 1'b0;
    w_pcl_ld  = 1'b0;
    w_pch_ld  = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start)
          w_next = S_F1;
      end
      S_F1: begin
        w_dl_wa  = 1'b1;
        w_pc_inc = 1'b1;
        case (r_mode)
          M_IMM:   w_next = S_D_DB;
          M_ZP:    w_next = S_D_ZP;
          default: w_next = S_F2;
        endcase
      end
      S_D_DB: begin
        w_dl_oadb = 1'b1;
        w_done    = 1'b1;
        w_next    = S_IDLE;
      end
      S_D_ZP: begin
        w_dl_oaal = 1'b1;
        w_abl_ld  = 1'b1;
        w_abh_clr = 1'b1;
        w_done    = 1'b1;
        w_next    = S_IDLE;
      end
      S_F2: begin
        w_dl_wa   = 1'b1;
        w_pc_inc  = 1'b1;
        w_dl_oaal = 1'b1;
        w_abl_ld  = 1'b1;
        w_next    = (r_mode == M_ABS) ? S_D_HI : S_P_SET;
      end
      S_D_HI: begin
        w_dl_oaah = 1'b1;
        w_abh_ld  = 1'b1;
        w_done    = 1'b1;
        w_next    = S_IDLE;
      end
      S_P_SET: begin
        w_dl_oaah = 1'b1;
        w_abh_ld  = 1'b1;
        w_next    = S_P_LO;
      end
      S_P_LO: begin
        addr_sel  = 1'b1;
        w_dl_wa   = 1'b1;
        w_abl_inc = 1'b1;
        w_next    = S_P_HI;
      end
      S_P_HI: begin
        addr_sel  = 1'b1;
        w_dl_wa   = 1'b1;
        w_dl_oaal = 1'b1;
        w_pcl_ld  = 1'b1;
        w_next    = S_D_PC;
      end
      S_D_PC: begin
        w_dl_oaah = 1'b1;
        w_pch_ld  = 1'b1;
        w_done    = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // a stall freezes the sequence; strobes are gated below
    if (r_state != S_IDLE && !w_run)
      w_next = r_state;
  end

  assign busy    = (r_state != S_IDLE);
  assign pc_inc  = w_pc_inc  & w_run;
  assign dl_wa   = w_dl_wa   & w_run;
  assign dl_oadb = w_dl_oadb & w_run;
  assign dl_oaal = w_dl_oaal & w_run;
  assign dl_oaah = w_dl_oaah & w_run;
  assign abl_ld  = w_abl_ld  & w_run;
  assign abh_ld  = w_abh_ld  & w_run;
  assign abh_clr = w_abh_clr & w_run;
  assign abl_inc = w_abl_inc & w_run;
  assign pcl_ld  = w_pcl_ld  & w_run;
  assign pch_ld  = w_pch_ld  & w_run;
  assign done    = w_done    & w_run;

endmodule

// File: tb/tb_operand_fetch_seq.sv
// tb_operand_fetch_seq: drives operand_fetch_seq inside a byte-level
// datapath and memory, comparing results against mode-level arithmetic.
module tb_operand_fetch_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       rdy = 1'b1;
  logic [1:0] mode = 2'd0;

  logic addr_sel, pc_inc, dl_wa, dl_oadb, dl_oaal, dl_oaah;
  logic abl_ld, abh_ld, abh_clr, abl_inc, pcl_ld, pch_ld, busy, done;
  logic addr_sel0, pc_inc0, dl_wa0, dl_oadb0, dl_oaal0, dl_oaah0;
  logic abl_ld0, abh_ld0, abh_clr0, abl_inc0, pcl_ld0, pch_ld0, busy0, done0;

  logic [11:0] strb;
  logic [13:0] all_o;
  assign strb = {pc_inc, dl_wa, dl_oadb, dl_oaal, dl_oaah, abl_ld,
                 abh_ld, abh_clr, abl_inc, pcl_ld, pch_ld, done};
  assign all_o = {addr_sel, busy, strb};

  operand_fetch_seq #(.RDY_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .rdy(rdy),
    .addr_sel(addr_sel), .pc_inc(pc_inc), .dl_wa(dl_wa),
    .dl_oadb(dl_oadb), .dl_oaal(dl_oaal), .dl_oaah(dl_oaah),
    .abl_ld(abl_ld), .abh_ld(abh_ld), .abh_clr(abh_clr),
    .abl_inc(abl_inc), .pcl_ld(pcl_ld), .pch_ld(pch_ld),
    .busy(busy), .done(done)
  );

  operand_fetch_seq #(.RDY_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .rdy(rdy),
    .addr_sel(addr_sel0), .pc_inc(pc_inc0), .dl_wa(dl_wa0),
    .dl_oadb(dl_oadb0), .dl_oaal(dl_oaal0), .dl_oaah(dl_oaah0),
    .abl_ld(abl_ld0), .abh_ld(abh_ld0), .abh_clr(abh_clr0),
    .abl_inc(abl_inc0), .pcl_ld(pcl_ld0), .pch_ld(pch_ld0),
    .busy(busy0), .done(done0)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] pc, pc_init;
  logic [7:0]  abl, abh, dl, db_val, abl_init, abh_init;
  bit          bad_read;
  int          req_n = 0;
  int          ack_n = 0;

  // byte-level datapath around the sequencer
  always @(posedge clk) begin : dpath
    logic [15:0] a;
    logic [7:0]  adl, adh;
    if (req_n != ack_n) begin
      pc = pc_init;
      abl = abl_init;
      abh = abh_init;
      bad_read = 1'b0;
      ack_n = req_n;
    end
    a   = addr_sel ? {abh, abl} : pc;
    adl = dl_oaal ? dl : 8'h00;
    adh = dl_oaah ? dl : 8'h00;
    if (dl_oadb) db_val = dl;
    if (dl_wa) begin
      if (a == 16'h3100) bad_read = 1'b1;
      dl = mem[a];
    end
    if (abl_ld)  abl = adl;
    if (abl_inc) abl = abl + 8'd1;
    if (abh_ld)  abh = adh;
    if (abh_clr) abh = 8'h00;
    if (pc_inc)  pc = pc + 16'd1;
    if (pcl_ld)  pc[7:0] = adl;
    if (pch_ld)  pc[15:8] = adh;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_inv();
    chk("drv_onehot",
        32'($countones({dl_oadb, dl_oaal, dl_oaah}) <= 1), 32'd1);
    chk("pcinc_pcaddr", 32'(!pc_inc || !addr_sel), 32'd1);
    chk("ablinc_ld", 32'(!(abl_inc && abl_ld)), 32'd1);
    chk("done_busy", 32'(!done || busy), 32'd1);
    if (busy && !rdy)
      chk("stall_strobes", 32'(strb), 32'd0);
  endtask

  task automatic run_op(input logic [1:0] m, input logic [15:0] p0,
                        input int pct, input int s_at, input int s_len,
                        input bit hold);
    logic [15:0] e_pc;
    logic [7:0]  e_abl, e_abh, lo, hi, lo1;
    int base, incs, cyc, stl, n_inc;
    bit got, stall;
    pc_init  = p0;
    abl_init = 8'($urandom);
    abh_init = 8'($urandom);
    req_n++;
    lo  = mem[p0];
    hi  = mem[p0 + 16'd1];
    lo1 = lo + 8'd1;
    case (m)
      2'd0: begin
        base = 2; incs = 1; e_pc = p0 + 16'd1;
        e_abl = abl_init; e_abh = abh_init;
      end
      2'd1: begin
        base = 2; incs = 1; e_pc = p0 + 16'd1;
        e_abl = lo; e_abh = 8'h00;
      end
      2'd2: begin
        base = 3; incs = 2; e_pc = p0 + 16'd2;
        e_abl = lo; e_abh = hi;
      end
      default: begin
        base = 6; incs = 2;
        e_pc = {mem[{hi, lo1}], mem[{hi, lo}]};
        e_abl = lo1; e_abh = hi;
      end
    endcase
    @(negedge clk);
    start = 1'b1;
    mode = m;
    rdy = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    mode = 2'($urandom_range(0, 3));
    cyc = 0; stl = 0; n_inc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      stall = ((cyc + 1) >= s_at) && ((cyc + 1) < s_at + s_len);
      rdy = !stall && ($urandom_range(0, 99) >= pct);
      #1;
      cyc++;
      check_inv();
      if (!rdy) stl++;
      if (pc_inc) n_inc++;
      if (cyc == 1 && rdy)
        chk("f1_strobes", 32'({addr_sel, dl_wa, pc_inc}), 32'h3);
      if (done) got = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    rdy = 1'b1;
    chk("done_seen", 32'(got), 32'd1);
    chk("cycles", 32'(cyc), 32'(base + stl));
    chk("pc_incs", 32'(n_inc), 32'(incs));
    @(posedge clk);
    #1;
    chk("no_restart", 32'({busy, done}), 32'd0);
    chk("pc", 32'(pc), 32'(e_pc));
    chk("abl", 32'(abl), 32'(e_abl));
    chk("abh", 32'(abh), 32'(e_abh));
    if (m == 2'd0)
      chk("db", 32'(db_val), 32'(lo));
  endtask

  int n;
  bit got;

  initial begin
    for (int i = 0; i < 65536; i++)
      mem[i] = 8'($urandom);
    #2 rst_n = 1'b0;
    #1 chk("reset_outs", 32'(all_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // abort an IND sequence in P_LO with reset
    mem[16'h0500] = 8'h10;
    mem[16'h0501] = 8'h20;
    pc_init = 16'h0500; abl_init = 8'h00; abh_init = 8'h00; req_n++;
    @(negedge clk);
    start = 1'b1; mode = 2'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("plo_reached", 32'({addr_sel, dl_wa, abl_inc}), 32'h7);
    rst_n = 1'b0;
    #1 chk("abort_outs", 32'(all_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    mem[16'h0200] = 8'hA5;
    run_op(2'd0, 16'h0200, 0, 0, 0, 1'b0);

    mem[16'h0300] = 8'h34;
    mem[16'h0301] = 8'h12;
    run_op(2'd2, 16'h0300, 0, 0, 0, 1'b0);
    run_op(2'd2, 16'h0300, 0, 2, 3, 1'b0);

    mem[16'h0400] = 8'hFF;
    mem[16'h0401] = 8'h30;
    mem[16'h30FF] = 8'h80;
    mem[16'h3000] = 8'h40;
    mem[16'h3100] = 8'h55;
    run_op(2'd3, 16'h0400, 0, 0, 0, 1'b0);
    chk("ind_pc_wrap", 32'(pc), 32'h4080);
    chk("no_read_3100", 32'(bad_read), 32'd0);

    run_op(2'd1, 16'h0600, 0, 0, 0, 1'b1);
    run_op(2'd3, 16'h0700, 0, 0, 0, 1'b1);

    for (int k = 0; k < 40; k++)
      run_op(2'($urandom_range(0, 3)), 16'($urandom), 25, 0, 0,
             1'($urandom_range(0, 1)));

    // rdy low: RDY_EN=0 copy runs, RDY_EN=1 copy holds in F1
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rdy = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 2'd2;
    @(negedge clk);
    start = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      #1;
      n++;
      chk("rdyen1_stall", 32'({addr_sel, busy, strb}), 32'h1000);
      if (done0) got = 1'b1;
      @(negedge clk);
    end
    chk("rdyen0_cycles", 32'(n), 32'd3);
    rdy = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      #1;
      n++;
      if (done) got = 1'b1;
      @(negedge clk);
    end
    chk("rdyen1_resume", 32'(n), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch_seq.md
Name: operand_fetch_seq

Overview:
- Sequences the input data latch during operand fetch.
- Issues latch write strobes on memory read cycles.
- Steers latched bytes onto DB, ADL or ADH.
- Loads the address-bus, PC-low and PC-high registers for the immediate, zero-page, absolute and JMP-indirect modes.
- Sits between instruction decode (start/mode) and the datapath registers; the block stores no data itself.

Parameters:
RDY_EN, 1, 1: rdy input stalls the sequencer; 0: rdy ignored (treated as 1)

Ports:
clk  in  1  system clock, all state changes on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin operand fetch; sampled only in IDLE
mode  in  2  0 IMM, 1 ZP, 2 ABS, 3 IND (JMP indirect); sampled with start
rdy  in  1  memory ready; 0 = stall current state
addr_sel  out  1  external address source: 0 PC, 1 ABL/ABH
pc_inc  out  1  increment PC at end of cycle
dl_wa  out  1  input latch write enable (captures memory data this posedge)
dl_oadb  out  1  latch drives DB
dl_oaal  out  1  latch drives ADL
dl_oaah  out  1  latch drives ADH
abl_ld  out  1  load ABL from ADL
abh_ld  out  1  load ABH from ADH
abh_clr  out  1  clear ABH to 8'h00
abl_inc  out  1  ABL+1, no carry into ABH (page wrap)
pcl_ld  out  1  load PCL from ADL
pch_ld  out  1  load PCH from ADH
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in the final state of a sequence

Behaviour:
- All outputs are combinational decodes of state (and rdy); the state register is the only storage.
- Reset (async, rst_n=0): state=IDLE; all outputs 0. Reset mid-sequence aborts immediately, with no done.
- Latch timing: a state with dl_wa captures data at its closing posedge. Drive enables in a later state present the stored byte. Write and drive may coexist in one state: the old byte is driven and the new byte captured.
- Stall: when rdy=0 (RDY_EN=1) in any non-IDLE state, the state holds and every strobe output is forced to 0. busy stays 1; addr_sel keeps its state value. In IDLE, rdy is ignored.
- IDLE: start=1 latches mode and goes to F1. start while busy is ignored. A new start is accepted only one cycle after done.
- F1: addr_sel=0, dl_wa, pc_inc. Next state by mode: IMM→D_DB, ZP→D_ZP, ABS/IND→F2.
- D_DB: dl_oadb, done → IDLE.
- D_ZP: dl_oaal, abl_ld, abh_clr, done → IDLE.
- F2: addr_sel=0, dl_wa, pc_inc, dl_oaal, abl_ld. Next: ABS→D_HI, IND→P_SET.
- D_HI: dl_oaah, abh_ld, done → IDLE.
- P_SET: dl_oaah, abh_ld → P_LO.
- P_LO: addr_sel=1, dl_wa, abl_inc → P_HI.
- P_HI: addr_sel=1, dl_wa, dl_oaal, pcl_ld → D_PC.
- D_PC: dl_oaah, pch_ld, done → IDLE.
- Cycle counts without stall, start to done inclusive of done cycle: IMM 2, ZP 2, ABS 3, IND 6.
- Invariants (assert):
  - At most one of dl_oadb/dl_oaal/dl_oaah is high.
  - pc_inc implies addr_sel=0.
  - abl_inc and abl_ld are never both high.
  - done implies busy.
- Pointer page wrap: abl_inc never carries. A pointer at xxFF fetches the high byte from xx00.

Test Plan:
- Reset: rst_n low mid-sequence, at the P_LO cycle of IND → all outputs 0 within the same cycle, state IDLE; a later start works.
- IMM: memory[PC=0x0200]=0xA5 → cycle1 dl_wa, pc_inc; cycle2 dl_oadb with DB=0xA5, done; PC=0x0201.
- ABS: bytes 0x34, 0x12 → ABL=0x34 after cycle2, ABH=0x12 after cycle3, done on cycle3; PC advanced by 2.
- IND wrap: pointer bytes 0xFF, 0x30; mem[0x30FF]=0x80, mem[0x3000]=0x40 → PCL=0x80, PCH=0x40, done on cycle6. mem[0x3100] must not be read.
- Stall: rdy=0 for 3 cycles during F2 of ABS → state held, all strobes 0; completes 3 cycles late with ABL/ABH correct; pc_inc counted once.
- start asserted while busy, and start on the done cycle → ignored; a single done per accepted start. With RDY_EN=0, rdy=0 has no effect.
